// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: START/WRITE/READ/STOP commands to open-drain scl/sda.
// Define I2C_MASTER_CLK_STRETCH_EN to honour slave clock stretching.
module i2c_byte_master #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_code,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_nack,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_nack,
  output logic                  rsp_err,
  output logic                  bus_owned,
  input  logic                  scl_i,
  output logic                  scl_oe,
  input  logic                  sda_i,
  output logic                  sda_oe
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, START, WBIT, RACK, RBIT, WACK, STOP, RESP
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt;
  logic [1:0]            q;
  logic [BW-1:0]         bitn;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  nack_l;
  logic                  ack_smp;
  logic                  sda_last;
  logic                  bus_st;
  logic                  stall;
  logic                  tick;
  logic                  qend;
  logic                  smp;

  assign bus_st = (state != IDLE) && (state != RESP);

`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign stall = bus_st & ~scl_oe & ~scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign stall = 1'b0;
`endif

  assign tick = bus_st & ~stall & (cnt == CNT_LAST);
  assign qend = tick & (q == 2'd3);
  assign smp  = tick & (q == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (cmd_valid) begin
        unique case (cmd_code)
          2'd0: state_n = START;
          2'd1: state_n = bus_owned ? WBIT : RESP;
          2'd2: state_n = bus_owned ? RBIT : RESP;
          2'd3: state_n = bus_owned ? STOP : RESP;
        endcase
      end
      START: if (qend) state_n = RESP;
      WBIT:  if (qend && bitn == BIT_LAST) state_n = RACK;
      RACK:  if (qend) state_n = RESP;
      RBIT:  if (qend && bitn == BIT_LAST) state_n = WACK;
      WACK:  if (qend) state_n = RESP;
      STOP:  if (qend) state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    scl_oe    = bus_owned;
    sda_oe    = bus_owned & sda_last;
    unique case (state)
      START: begin
        scl_oe = (q == 2'd0) ? bus_owned : (q == 2'd3);
        sda_oe = q[1];
      end
      WBIT: begin
        scl_oe = (q == 2'd0) || (q == 2'd3);
        sda_oe = ~shreg[DATA_WIDTH-1];
      end
      RACK, RBIT: begin
        scl_oe = (q == 2'd0) || (q == 2'd3);
        sda_oe = 1'b0;
      end
      WACK: begin
        scl_oe = (q == 2'd0) || (q == 2'd3);
        sda_oe = ~nack_l;
      end
      STOP: begin
        scl_oe = (q == 2'd0);
        sda_oe = ~q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      q         <= '0;
      bitn      <= '0;
      shreg     <= '0;
      nack_l    <= 1'b0;
      ack_smp   <= 1'b0;
      sda_last  <= 1'b0;
      bus_owned <= 1'b0;
      rsp_data  <= '0;
      rsp_nack  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        cnt  <= '0;
        q    <= '0;
        bitn <= '0;
        if (cmd_valid) begin
          shreg  <= cmd_data;
          nack_l <= cmd_nack;
        end
      end else if (bus_st && !stall) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (tick) q <= q + 2'd1;
      end
      if (qend && (state == WBIT || state == RBIT))
        bitn <= (bitn == BIT_LAST) ? '0 : bitn + 1'b1;
      if (qend && state == WBIT)
        shreg <= shreg << 1;
      if (smp && state == RBIT)
        shreg <= {shreg[DATA_WIDTH-2:0], sda_i};
      if (smp && state == RACK)
        ack_smp <= sda_i;
      // remembered so sda stays put while the bus idles between commands
      if (bus_st) sda_last <= sda_oe;
      if (qend && state == START) bus_owned <= 1'b1;
      if (qend && state == STOP)  bus_owned <= 1'b0;
      if (state_n == RESP && state != RESP) begin
        rsp_err  <= (state == IDLE);
        rsp_nack <= (state == RACK) & ack_smp;
        if (state == WACK) rsp_data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with a small I2C slave model at 0x22.
// Slave returns 0x3C on reads; stretches scl in write bit 3 when enabled.
module tb_i2c_byte_master;

  localparam logic [7:0] TX = 8'h3C;
`ifdef I2C_MASTER_CLK_STRETCH_EN
  localparam int WR_LAT = 165;
`else
  localparam int WR_LAT = 145;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       rsp_err;
  logic       bus_owned;
  logic       scl_i;
  logic       scl_oe;
  logic       sda_i;
  logic       sda_oe;

  logic       slv_sda_low;
  logic       slv_scl_low;

  assign scl_i = ~scl_oe & ~slv_scl_low;
  assign sda_i = ~sda_oe & ~slv_sda_low;

  always #5 clk = ~clk;

  i2c_byte_master #(.CLK_DIV(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_data  (cmd_data),
    .cmd_nack  (cmd_nack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_nack  (rsp_nack),
    .rsp_err   (rsp_err),
    .bus_owned (bus_owned),
    .scl_i     (scl_i),
    .scl_oe    (scl_oe),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe)
  );

  // slave model
  logic       prev_scl, prev_sda;
  logic [1:0] phase;
  logic [3:0] bitcnt;
  logic [7:0] shift, txsh, wr_byte;
  logic [4:0] scnt;
  logic       mack, done;
  int         nwr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_scl    <= 1'b1;
      prev_sda    <= 1'b1;
      phase       <= 2'd0;
      bitcnt      <= 4'd0;
      shift       <= 8'h00;
      txsh        <= 8'h00;
      wr_byte     <= 8'h00;
      slv_sda_low <= 1'b0;
      slv_scl_low <= 1'b0;
      scnt        <= 5'd0;
      mack        <= 1'b0;
      done        <= 1'b0;
      nwr         <= 0;
    end else begin
      prev_scl <= scl_i;
      prev_sda <= sda_i;
      if (prev_scl && scl_i && prev_sda && !sda_i) begin
        phase       <= 2'd1;
        bitcnt      <= 4'd0;
        slv_sda_low <= 1'b0;
      end else if (prev_scl && scl_i && !prev_sda && sda_i) begin
        phase       <= 2'd0;
        slv_sda_low <= 1'b0;
      end else if (!prev_scl && scl_i && phase != 2'd0) begin
        if (bitcnt < 4'd8) shift <= {shift[6:0], sda_i};
        else if (phase == 2'd3) mack <= sda_i;
        bitcnt <= bitcnt + 4'd1;
      end else if (prev_scl && !scl_i && phase != 2'd0) begin
        if (bitcnt == 4'd8) begin
          if (phase == 2'd3) slv_sda_low <= 1'b0;
          else if (phase == 2'd1 && shift[7:1] != 7'h22) phase <= 2'd0;
          else begin
            slv_sda_low <= 1'b1;
            if (phase == 2'd2) begin
              wr_byte <= shift;
              nwr     <= nwr + 1;
            end
          end
        end else if (bitcnt == 4'd9) begin
          bitcnt <= 4'd0;
          if ((phase == 2'd1 && shift[0]) || (phase == 2'd3 && !mack)) begin
            phase       <= 2'd3;
            slv_sda_low <= ~TX[7];
            txsh        <= {TX[6:0], 1'b0};
          end else begin
            slv_sda_low <= 1'b0;
            if (phase == 2'd1) phase <= 2'd2;
            if (phase == 2'd3) begin
              phase <= 2'd0;
              done  <= 1'b1;
            end
          end
        end else if (phase == 2'd3) begin
          slv_sda_low <= ~txsh[7];
          txsh        <= {txsh[6:0], 1'b0};
        end
`ifdef I2C_MASTER_CLK_STRETCH_EN
        if (phase == 2'd2 && bitcnt == 4'd3) begin
          slv_scl_low <= 1'b1;
          scnt        <= 5'd0;
        end
`endif
      end
      if (slv_scl_low && !scl_oe) begin
        scnt <= scnt + 5'd1;
        if (scnt == 5'd19) slv_scl_low <= 1'b0;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] r_data;
  logic       r_nack, r_err, r_scl, r_sda;

  // called #1 after an edge with the DUT idle; returns #1 after RESP->IDLE
  task automatic cmd(input logic [1:0] code, input logic [7:0] data,
                     input logic nack, output int lat);
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_data  = data;
    cmd_nack  = nack;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    cmd_nack  = ~nack;
    lat = 1;
    while (!rsp_valid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    r_data = rsp_data;
    r_nack = rsp_nack;
    r_err  = rsp_err;
    r_scl  = scl_oe;
    r_sda  = sda_oe;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_code  = 2'd0;
    cmd_data  = 8'h00;
    cmd_nack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bus_owned", bus_owned, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_nack", rsp_nack, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);

    // write transfer to 0x22
    cmd(2'd0, 8'h00, 1'b0, lat);
    chk("t1_start_lat", lat, 17);
    chk("t1_start_err", r_err, 0);
    chk("t1_owned", bus_owned, 1);
    chk("t1_hold_scl", scl_oe, 1);
    chk("t1_hold_sda", sda_oe, 1);
    cmd(2'd1, 8'h44, 1'b0, lat);
    chk("t1_addr_nack", r_nack, 0);
    chk("t1_addr_lat", lat, 145);
    cmd(2'd1, 8'hA5, 1'b0, lat);
    chk("t1_data_nack", r_nack, 0);
    chk("t1_data_lat", lat, WR_LAT);
    chk("t1_data_err", r_err, 0);
    cmd(2'd3, 8'h00, 1'b0, lat);
    chk("t1_stop_lat", lat, 17);
    chk("t1_stop_err", r_err, 0);
    chk("t1_stop_owned", bus_owned, 0);
    chk("t1_stop_scl", scl_oe, 0);
    chk("t1_stop_sda", sda_oe, 0);
    chk("t1_bfm_byte", wr_byte, 8'hA5);
    chk("t1_bfm_nwr", nwr, 1);

    // read transfer with master NACK
    cmd(2'd0, 8'h00, 1'b0, lat);
    cmd(2'd1, 8'h45, 1'b0, lat);
    chk("t2_addr_nack", r_nack, 0);
    cmd(2'd2, 8'h00, 1'b1, lat);
    chk("t2_rd_data", r_data, 8'h3C);
    chk("t2_rd_err", r_err, 0);
    chk("t2_rd_nack", r_nack, 0);
    chk("t2_rd_lat", lat, 145);
    chk("t2_mack_high", mack, 1);
    chk("t2_bfm_done", done, 1);
    chk("t2_hold_rdata", rsp_data, 8'h3C);
    cmd(2'd3, 8'h00, 1'b0, lat);
    chk("t2_stop_err", r_err, 0);

    // absent address
    cmd(2'd0, 8'h00, 1'b0, lat);
    cmd(2'd1, 8'hA0, 1'b0, lat);
    chk("t3_addr_nack", r_nack, 1);
    cmd(2'd3, 8'h00, 1'b0, lat);
    chk("t3_stop_err", r_err, 0);
    chk("t3_stop_nack", r_nack, 0);
    chk("t3_scl_rel", scl_oe, 0);
    chk("t3_sda_rel", sda_oe, 0);
    chk("t3_owned", bus_owned, 0);

    // commands that need the bus while idle
    cmd(2'd1, 8'h11, 1'b0, lat);
    chk("t4_wr_err", r_err, 1);
    chk("t4_wr_lat_ok", {31'd0, lat <= 2}, 1);
    chk("t4_wr_scl", r_scl, 0);
    chk("t4_wr_sda", r_sda, 0);
    chk("t4_scl_after", scl_oe, 0);
    chk("t4_sda_after", sda_oe, 0);
    cmd(2'd2, 8'h00, 1'b0, lat);
    chk("t4_rd_err", r_err, 1);
    cmd(2'd3, 8'h00, 1'b0, lat);
    chk("t4_stop_err", r_err, 1);
    chk("t4_owned", bus_owned, 0);

    // reset in the middle of a byte
    cmd(2'd0, 8'h00, 1'b0, lat);
    cmd_valid = 1'b1;
    cmd_code  = 2'd1;
    cmd_data  = 8'h44;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (78) @(posedge clk);
    #1;
    chk("t5_pre_scl", scl_oe, 1);
    chk("t5_pre_sda", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_scl", scl_oe, 0);
    chk("t5_rst_sda", sda_oe, 0);
    chk("t5_rst_owned", bus_owned, 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_ready", cmd_ready, 1);
    chk("t5_rsp_valid", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
